// File: rtl/food_manager.sv
// Food placement, eat detection and length/score growth for the snake game.
// A free-running LFSR supplies candidate positions; accepted food is plotted once.
//
// state | meaning
// PICK  | test one LFSR candidate per cycle against range and latched head
// DRAW  | one-cycle food pixel plot request
// WAIT  | idle, accept food_en and latch the head position
// CHECK | compare latched head with food, grow on a hit
module food_manager #(
  parameter int          MAX_X       = 160,
  parameter int          MAX_Y       = 120,
  parameter int          INIT_LENGTH = 3,
  parameter int          GROW        = 1,
  parameter int          MAX_LENGTH  = 2047,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [2:0]  FOOD_COLOUR = 3'b100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        food_en,
  input  logic [7:0]  head_x,
  input  logic [6:0]  head_y,
  output logic [10:0] length,
  output logic [7:0]  food_x,
  output logic [6:0]  food_y,
  output logic [7:0]  plot_x,
  output logic [6:0]  plot_y,
  output logic        plot_en,
  output logic [2:0]  colour_out,
  output logic        ate,
  output logic [9:0]  score,
  output logic        busy
);

  typedef enum logic [1:0] {
    PICK  = 2'd0,
    DRAW  = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  // An all-zero seed would lock the LFSR, so fall back to a known-good value.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [8:0]  MAX_X_W   = 9'(MAX_X);
  localparam logic [7:0]  MAX_Y_W   = 8'(MAX_Y);
  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LENGTH);
  localparam logic [11:0] GROW_W    = 12'(GROW);
  localparam logic [10:0] MAX_SCORE = 11'd1023;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic [7:0]  head_x_q;
  logic [6:0]  head_y_q;

  logic [7:0]  cand_x;
  logic [6:0]  cand_y;
  logic        accept;
  logic        hit;
  logic [11:0] len_sum;
  logic [10:0] len_nxt;
  logic [10:0] score_sum;
  logic [9:0]  score_nxt;

  assign cand_x = lfsr[7:0];
  assign cand_y = lfsr[14:8];
  assign accept = ({1'b0, cand_x} < MAX_X_W) &&
                  ({1'b0, cand_y} < MAX_Y_W) &&
                  !((cand_x == head_x_q) && (cand_y == head_y_q));
  assign hit    = (head_x_q == food_x) && (head_y_q == food_y);

  // Widen before adding so the saturation compare sees the carry.
  assign len_sum   = {1'b0, length} + GROW_W;
  assign len_nxt   = (len_sum > MAX_LEN_W) ? MAX_LEN_W[10:0] : len_sum[10:0];
  assign score_sum = {1'b0, score} + 11'd1;
  assign score_nxt = (score_sum > MAX_SCORE) ? MAX_SCORE[9:0] : score_sum[9:0];

  always_comb begin
    state_nxt = state;
    case (state)
      PICK:    if (accept) state_nxt = DRAW;
      DRAW:    state_nxt = WAIT;
      WAIT:    if (food_en) state_nxt = CHECK;
      CHECK:   state_nxt = hit ? PICK : WAIT;
      default: state_nxt = PICK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PICK;
      lfsr       <= SEED_EFF;
      head_x_q   <= '0;
      head_y_q   <= '0;
      length     <= 11'(INIT_LENGTH);
      score      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      plot_x     <= '0;
      plot_y     <= '0;
      plot_en    <= 1'b0;
      colour_out <= '0;
      ate        <= 1'b0;
      busy       <= 1'b1;
    end else begin
      // Taps 16,14,13,11 in right-shifting Fibonacci form.
      lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      state   <= state_nxt;
      busy    <= (state_nxt != WAIT);
      plot_en <= (state == PICK) && accept;
      ate     <= (state == CHECK) && hit;
      if ((state == PICK) && accept) begin
        food_x     <= cand_x;
        food_y     <= cand_y;
        plot_x     <= cand_x;
        plot_y     <= cand_y;
        colour_out <= FOOD_COLOUR;
      end
      if ((state == WAIT) && food_en) begin
        head_x_q <= head_x;
        head_y_q <= head_y;
      end
      if ((state == CHECK) && hit) begin
        length <= len_nxt;
        score  <= score_nxt;
      end
    end
  end

endmodule
